vend_txn_ctrl: RTL and testbench

Transaction controller for the candy vending datapath. Accumulates inserted coin credit and sequences a request/acknowledge handshake to the candy dispenser once the price is reached. It then pays out change as dimes and nickels through a second handshake. Handles cancel, idle-timeout refund and coin rejection while a transaction is in flight.

---
 rtl/vend_txn_ctrl_if.sv | 31 +++
 rtl/vend_txn_ctrl.sv | 178 +++++++++++++++++
 tb/tb_vend_txn_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_txn_ctrl_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// vend_txn_ctrl_if : coin / dispenser / hopper handshake bundle
// Rev 1.0
// -----------------------------------------------------------------------------
interface vend_txn_ctrl_if #(
    parameter int CREDIT_W = 6
);
    logic                coin_valid;
    logic [1:0]          coin_type;
    logic                cancel;
    logic                vend_ack;
    logic                chg_ack;
    logic                vend_req;
    logic                chg_req;
    logic                chg_coin;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
    logic                coin_reject;

    modport master (
        input  coin_valid, coin_type, cancel, vend_ack, chg_ack,
        output vend_req, chg_req, chg_coin, credit, busy, coin_reject
    );

    modport slave (
        output coin_valid, coin_type, cancel, vend_ack, chg_ack,
        input  vend_req, chg_req, chg_coin, credit, busy, coin_reject
    );
endinterface
`default_nettype wire

// File: rtl/vend_txn_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// vend_txn_ctrl : credit accumulation, vend handshake and dime/nickel change
// Rev 1.0
// -----------------------------------------------------------------------------
module vend_txn_ctrl #(
    parameter int PRICE       = 25,
    parameter int CREDIT_W    = 6,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    vend_txn_ctrl_if.master        bus
);

    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [CREDIT_W-1:0] C_PRICE    = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] C_NICKEL   = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] C_DIME     = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] C_QUARTER  = CREDIT_W'(25);
    localparam logic [TMO_W-1:0]    C_TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0]    C_TMO_ONE  = TMO_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_CHANGE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic [TMO_W-1:0]    r_tmo;
    logic [TMO_W-1:0]    w_tmo_nxt;
    logic                r_vend_req;
    logic                r_chg_req;
    logic                r_chg_coin;
    logic                r_busy;
    logic                r_reject;
    logic                w_vend_req_nxt;
    logic                w_chg_req_nxt;
    logic                w_chg_coin_nxt;
    logic                w_busy_nxt;
    logic                w_reject_nxt;

    logic [CREDIT_W-1:0] w_coin_val;
    logic                w_coin_ok;
    logic [CREDIT_W-1:0] w_sum;
    logic [CREDIT_W-1:0] w_pay;

    always_comb begin
        w_coin_val = '0;
        case (bus.coin_type)
            2'd0:    w_coin_val = C_NICKEL;
            2'd1:    w_coin_val = C_DIME;
            2'd2:    w_coin_val = C_QUARTER;
            default: w_coin_val = '0;
        endcase
    end

    assign w_coin_ok = bus.coin_valid && (bus.coin_type != 2'd3);
    // Credit stays below PRICE while collecting, so the sum cannot wrap.
    assign w_sum     = r_credit + w_coin_val;
    assign w_pay     = r_chg_coin ? C_DIME : C_NICKEL;

    always_comb begin
        w_state_nxt   = r_state;
        w_credit_nxt  = r_credit;
        w_tmo_nxt     = r_tmo;
        w_chg_req_nxt = 1'b0;
        w_reject_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_tmo_nxt = '0;
                if (w_coin_ok) begin
                    w_credit_nxt = w_sum;
                    w_state_nxt  = (w_sum >= C_PRICE) ? S_VEND : S_COLLECT;
                end else if (bus.coin_valid) begin
                    w_reject_nxt = 1'b1;
                end
            end

            S_COLLECT: begin
                w_reject_nxt = bus.coin_valid && !w_coin_ok;
                if (w_coin_ok) begin
                    w_credit_nxt = w_sum;
                    w_tmo_nxt    = '0;
                    if (w_sum >= C_PRICE) begin
                        w_state_nxt = S_VEND;
                    end else if (bus.cancel) begin
                        w_state_nxt = S_CHANGE;
                    end
                end else if (bus.cancel) begin
                    w_state_nxt = S_CHANGE;
                end else if (r_tmo == C_TMO_LAST) begin
                    w_state_nxt = S_CHANGE;
                end else begin
                    w_tmo_nxt = r_tmo + C_TMO_ONE;
                end
            end

            S_VEND: begin
                w_reject_nxt = bus.coin_valid;
                if (bus.vend_ack && r_vend_req) begin
                    w_credit_nxt = r_credit - C_PRICE;
                    w_state_nxt  = (r_credit == C_PRICE) ? S_IDLE : S_CHANGE;
                end
            end

            S_CHANGE: begin
                w_reject_nxt = bus.coin_valid;
                if (r_chg_req) begin
                    if (bus.chg_ack) begin
                        // Request drops for one cycle after every paid coin.
                        w_credit_nxt = r_credit - w_pay;
                        if (r_credit == w_pay) begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_chg_req_nxt = 1'b1;
                    end
                end else begin
                    w_chg_req_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if ((w_state_nxt == S_CHANGE) && (r_state != S_CHANGE)) begin
            w_chg_req_nxt = 1'b1;
        end
        if (w_state_nxt != S_COLLECT) begin
            w_tmo_nxt = '0;
        end
    end

    assign w_vend_req_nxt = (w_state_nxt == S_VEND);
    assign w_busy_nxt     = (w_state_nxt == S_VEND) || (w_state_nxt == S_CHANGE);
    assign w_chg_coin_nxt = w_chg_req_nxt && (w_credit_nxt >= C_DIME);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_credit   <= '0;
            r_tmo      <= '0;
            r_vend_req <= 1'b0;
            r_chg_req  <= 1'b0;
            r_chg_coin <= 1'b0;
            r_busy     <= 1'b0;
            r_reject   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_credit   <= w_credit_nxt;
            r_tmo      <= w_tmo_nxt;
            r_vend_req <= w_vend_req_nxt;
            r_chg_req  <= w_chg_req_nxt;
            r_chg_coin <= w_chg_coin_nxt;
            r_busy     <= w_busy_nxt;
            r_reject   <= w_reject_nxt;
        end
    end

    assign bus.vend_req    = r_vend_req;
    assign bus.chg_req     = r_chg_req;
    assign bus.chg_coin    = r_chg_coin;
    assign bus.credit      = r_credit;
    assign bus.busy        = r_busy;
    assign bus.coin_reject = r_reject;

endmodule
`default_nettype wire

// File: tb/tb_vend_txn_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_vend_txn_ctrl : directed and random stimulus against a transaction model
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_vend_txn_ctrl;

    localparam int PRICE       = 25;
    localparam int CREDIT_W    = 6;
    localparam int TIMEOUT_CYC = 255;

    localparam int P_IDLE    = 0;
    localparam int P_COLLECT = 1;
    localparam int P_VEND    = 2;
    localparam int P_CHANGE  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    vend_txn_ctrl_if #(.CREDIT_W(CREDIT_W)) bus ();

    vend_txn_ctrl #(
        .PRICE       (PRICE),
        .CREDIT_W    (CREDIT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: phase, credit, idle time, queue of coins to pay.
    int m_phase;
    int m_credit;
    int m_idle;
    int m_q[$];
    bit m_gap;
    bit m_reject;

    function automatic int cval(input int ct);
        return (ct == 0) ? 5 : (ct == 1) ? 10 : 25;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = P_IDLE;
        m_credit = 0;
        m_idle   = 0;
        m_q.delete();
        m_gap    = 1'b0;
        m_reject = 1'b0;
    endtask

    task automatic refund();
        int c;
        m_phase = P_CHANGE;
        m_gap   = 1'b0;
        m_q.delete();
        c = m_credit;
        while (c > 0) begin
            if (c >= 10) begin m_q.push_back(10); c -= 10; end
            else         begin m_q.push_back(5);  c -= 5;  end
        end
    endtask

    task automatic model_edge();
        bit cv;
        int ct;
        bit accepted;
        cv       = bus.coin_valid;
        ct       = int'(bus.coin_type);
        accepted = cv && (ct != 3);
        m_reject = 1'b0;
        case (m_phase)
            P_IDLE: begin
                if (accepted) begin
                    m_credit = cval(ct);
                    m_idle   = 0;
                    m_phase  = (m_credit >= PRICE) ? P_VEND : P_COLLECT;
                end else if (cv) begin
                    m_reject = 1'b1;
                end
            end
            P_COLLECT: begin
                if (cv && !accepted) m_reject = 1'b1;
                if (accepted) begin
                    m_credit += cval(ct);
                    m_idle    = 0;
                    if (m_credit >= PRICE) m_phase = P_VEND;
                    else if (bus.cancel)   refund();
                end else if (bus.cancel) begin
                    refund();
                end else begin
                    m_idle++;
                    if (m_idle >= TIMEOUT_CYC) refund();
                end
            end
            P_VEND: begin
                m_reject = cv;
                if (bus.vend_ack) begin
                    m_credit -= PRICE;
                    if (m_credit > 0) refund();
                    else              m_phase = P_IDLE;
                end
            end
            default: begin
                m_reject = cv;
                if (m_gap) begin
                    m_gap = 1'b0;
                end else if (bus.chg_ack) begin
                    m_credit -= m_q.pop_front();
                    if (m_q.size() == 0) m_phase = P_IDLE;
                    else                 m_gap   = 1'b1;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        bit exp_chg;
        exp_chg = (m_phase == P_CHANGE) && !m_gap;
        check("credit",      32'(bus.credit),      32'(m_credit));
        check("vend_req",    32'(bus.vend_req),    32'(m_phase == P_VEND));
        check("chg_req",     32'(bus.chg_req),     32'(exp_chg));
        check("chg_coin",    32'(bus.chg_coin),    32'(exp_chg && (m_q.size() > 0) && (m_q[0] == 10)));
        check("busy",        32'(bus.busy),        32'((m_phase == P_VEND) || (m_phase == P_CHANGE)));
        check("coin_reject", 32'(bus.coin_reject), 32'(m_reject));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic cyc(input bit cv, input logic [1:0] ct, input bit cn, input bit va, input bit ca);
        bus.coin_valid = cv;
        bus.coin_type  = ct;
        bus.cancel     = cn;
        bus.vend_ack   = va;
        bus.chg_ack    = ca;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.coin_valid = 1'b0;
        bus.coin_type  = 2'd0;
        bus.cancel     = 1'b0;
        bus.vend_ack   = 1'b0;
        bus.chg_ack    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Dime, dime, nickel: exact price, no change.
        cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        check("t1_credit10", 32'(bus.credit), 32'd10);
        cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        check("t1_credit20", 32'(bus.credit), 32'd20);
        cyc(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        check("t1_vend_req", 32'(bus.vend_req), 32'd1);
        cyc(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        check("t1_credit0", 32'(bus.credit), 32'd0);
        idle(2);

        // Dime then quarter: vend and one dime of change.
        cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        check("t2_credit35", 32'(bus.credit), 32'd35);
        idle(2);
        cyc(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        check("t2_chg_dime", 32'(bus.chg_coin), 32'd1);
        cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        check("t2_busy_off", 32'(bus.busy), 32'd0);
        idle(1);

        // Nickel, dime, cancel: dime then nickel with a gap.
        cyc(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        check("t3_credit15", 32'(bus.credit), 32'd15);
        cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        check("t3_gap", 32'(bus.chg_req), 32'd0);
        cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        check("t3_nickel", 32'(bus.chg_coin), 32'd0);
        cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        check("t3_done", 32'(bus.credit), 32'd0);

        // Idle timeout after one nickel.
        cyc(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        idle(TIMEOUT_CYC - 1);
        check("t4_no_timeout_yet", 32'(bus.chg_req), 32'd0);
        idle(1);
        check("t4_timeout", 32'(bus.chg_req), 32'd1);
        cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        // Quarter at cycle 200 restarts the timer and vends.
        cyc(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        idle(199);
        cyc(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        check("t4_vend", 32'(bus.vend_req), 32'd1);
        cyc(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

        // Rejections during VEND and for an invalid coin.
        cyc(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        check("t5_rej_vend", 32'(bus.coin_reject), 32'd1);
        cyc(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
        check("t5_rej_inv", 32'(bus.coin_reject), 32'd1);
        check("t5_credit", 32'(bus.credit), 32'd5);
        cyc(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset while a change coin is requested.
        cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        check("t6_chg_req", 32'(bus.chg_req), 32'd1);
        bus.cancel = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        check("t6_idle_after", 32'(bus.credit), 32'd5);

        // Random traffic, acks arrive freely and must be filtered.
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom % 4) == 0, 2'($urandom % 4), ($urandom % 16) == 0,
                ($urandom % 3) == 0, ($urandom % 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
